// File: rtl/dac_envelope_stage.sv
// dac_envelope_stage
//   Per-channel stage between the signal generator and the DAC interface.
//   Applies gain, a linear ramp-up/ramp-down envelope and a DC offset to
//   each signed sample, then clamps the result to the symmetric DAC range.
//   The envelope removes output steps when a channel is switched on or off.
//
// Ports
//   clk            sample clock
//   aresetn        synchronous reset, active-low
//   s_axis_tdata   signed input sample
//   s_axis_tvalid  input sample valid
//   cfg_data       [15:0] gain Q1.15 unsigned, [31:16] offset signed,
//                  [63:32] ramp_step unsigned (0 = jump in one sample)
//   enable         1 = ramp to full scale, 0 = ramp to zero
//   m_axis_tdata   clamped output, sign-extended DAC value
//   m_axis_tvalid  s_axis_tvalid delayed by the 3-stage pipeline
//   ramp_state     0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN
//   ramp_done      one-cycle pulse when the ramp-down reaches zero
//   clip_count     (DAC_ENVELOPE_CLIP_COUNT_EN only) saturating count of
//                  clamped output samples, cleared when a ramp-up starts
//
// Build option: define DAC_ENVELOPE_CLIP_COUNT_EN to add clip_count.
module dac_envelope_stage #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH        = 14,
  parameter int ENV_WIDTH        = 32,
  parameter int CFG_DATA_WIDTH   = 64
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                               s_axis_tvalid,
  input  logic        [CFG_DATA_WIDTH-1:0]   cfg_data,
  input  logic                               enable,
  output logic signed [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic        [1:0]                  ramp_state,
  output logic                               ramp_done
`ifdef DAC_ENVELOPE_CLIP_COUNT_EN
  ,
  output logic        [15:0]                 clip_count
`endif
);

  localparam int FRAC   = 15;
  localparam int GAIN_W = 16;
  localparam int ENVF_W = 16;
  localparam int MUL1_W = AXIS_TDATA_WIDTH + GAIN_W + 1;
  localparam int P1_W   = MUL1_W - FRAC;
  localparam int MUL2_W = P1_W + ENVF_W + 1;
  localparam int P2_W   = MUL2_W - FRAC;
  localparam int SUM_W  = P2_W + 1;

  localparam logic [ENV_WIDTH-1:0]    UNITY   = {1'b1, {(ENV_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(2**(DAC_WIDTH-1) - 1);
  localparam logic signed [SUM_W-1:0] SUM_MIN = -SUM_MAX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // A zero step means "jump straight to the end point".
  function automatic logic [ENV_WIDTH-1:0] env_up(input logic [ENV_WIDTH-1:0] e,
                                                  input logic [ENV_WIDTH-1:0] s);
    logic [ENV_WIDTH:0] sum;
    sum = {1'b0, e} + {1'b0, s};
    if (s == '0 || sum >= {1'b0, UNITY}) env_up = UNITY;
    else                                 env_up = sum[ENV_WIDTH-1:0];
  endfunction

  function automatic logic [ENV_WIDTH-1:0] env_dn(input logic [ENV_WIDTH-1:0] e,
                                                  input logic [ENV_WIDTH-1:0] s);
    if (s == '0 || s >= e) env_dn = '0;
    else                   env_dn = e - s;
  endfunction

  function automatic logic is_clip(input logic signed [SUM_W-1:0] v);
    is_clip = (v > SUM_MAX) || (v < SUM_MIN);
  endfunction

  function automatic logic signed [AXIS_TDATA_WIDTH-1:0] dac_clamp(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] c;
    if      (v > SUM_MAX) c = SUM_MAX;
    else if (v < SUM_MIN) c = SUM_MIN;
    else                  c = v;
    dac_clamp = c[AXIS_TDATA_WIDTH-1:0];
  endfunction

  // ---- configuration register: takes effect the cycle after it is applied
  logic        [GAIN_W-1:0]    gain_p0;
  logic signed [15:0]          offset_p0;
  logic        [ENV_WIDTH-1:0] step_p0;

  always_ff @(posedge clk) begin
    gain_p0   <= cfg_data[15:0];
    offset_p0 <= cfg_data[31:16];
    step_p0   <= cfg_data[63:32];
  end

  // ---- envelope FSM
  state_t                 state, state_nxt;
  logic [ENV_WIDTH-1:0]   env, env_nxt;
  logic                   done_nxt;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= IDLE;
      env       <= '0;
      ramp_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      env       <= env_nxt;
      ramp_done <= done_nxt;
    end
  end

  // enable is tested first so a direction change never lets env overshoot.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        env_nxt = '0;
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else begin
          if (s_axis_tvalid) env_nxt = env_up(env, step_p0);
          if (env_nxt == UNITY) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!enable) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_nxt = RAMP_UP;
        end else begin
          if (s_axis_tvalid) env_nxt = env_dn(env, step_p0);
          if (env_nxt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ramp_state = state;

  // ---- stage 1: gain; env is captured alongside so it tracks this sample
  logic signed [MUL1_W-1:0] mul1;
  logic signed [P1_W-1:0]   gained_p1;
  logic        [ENVF_W-1:0] envf_p1;
  logic                     vld_p1;

  assign mul1 = MUL1_W'(s_axis_tdata) * MUL1_W'($signed({1'b0, gain_p0}));

  // ---- stage 2: envelope
  logic signed [MUL2_W-1:0] mul2;
  logic signed [P2_W-1:0]   shaped_p2;
  logic                     vld_p2;

  assign mul2 = MUL2_W'(gained_p1) * MUL2_W'($signed({1'b0, envf_p1}));

  // ---- stage 3: offset and clamp
  logic signed [SUM_W-1:0]            sum_s3;
  logic signed [AXIS_TDATA_WIDTH-1:0] dac_p3;
  logic                               vld_p3;

  assign sum_s3 = SUM_W'(shaped_p2) + SUM_W'(offset_p0);

  // Data registers only load on valid so bubbles leave the output held.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      gained_p1 <= '0;
      envf_p1   <= '0;
      shaped_p2 <= '0;
      dac_p3    <= '0;
    end else begin
      vld_p1 <= s_axis_tvalid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (s_axis_tvalid) begin
        gained_p1 <= mul1[MUL1_W-1:FRAC];
        envf_p1   <= env[ENV_WIDTH-1 -: ENVF_W];
      end
      if (vld_p1) shaped_p2 <= mul2[MUL2_W-1:FRAC];
      if (vld_p2) dac_p3    <= dac_clamp(sum_s3);
    end
  end

  assign m_axis_tdata  = dac_p3;
  assign m_axis_tvalid = vld_p3;

`ifdef DAC_ENVELOPE_CLIP_COUNT_EN
  logic [15:0] clip_cnt;

  always_ff @(posedge clk) begin
    if (!aresetn)
      clip_cnt <= '0;
    else if (state == IDLE && enable)
      clip_cnt <= '0;
    else if (vld_p2 && is_clip(sum_s3) && clip_cnt != 16'hFFFF)
      clip_cnt <= clip_cnt + 16'd1;
  end

  assign clip_count = clip_cnt;
`endif

endmodule

// File: tb/tb_dac_envelope_stage.sv
// Scoreboard bench for dac_envelope_stage: each driven sample pushes its
// expected output, a negedge monitor pops and compares on m_axis_tvalid.
module tb_dac_envelope_stage;

  logic               clk = 1'b0;
  logic               aresetn;
  logic signed [15:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic [63:0]        cfg_data;
  logic               enable;
  logic signed [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic [1:0]         ramp_state;
  logic               ramp_done;
`ifdef DAC_ENVELOPE_CLIP_COUNT_EN
  logic [15:0]        clip_count;
`endif

  always #4 clk = ~clk;

  dac_envelope_stage dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .cfg_data      (cfg_data),
    .enable        (enable),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .ramp_state    (ramp_state),
    .ramp_done     (ramp_done)
`ifdef DAC_ENVELOPE_CLIP_COUNT_EN
    ,
    .clip_count    (clip_count)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int sb[$];

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (aresetn && m_axis_tvalid) begin
      if (sb.size() == 0) chk("sb_underflow", 64'sd1, 64'sd0);
      else chk("dout", m_axis_tdata, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drv(input logic signed [15:0] x, input int e);
    s_axis_tdata  = x;
    s_axis_tvalid = 1'b1;
    sb.push_back(e);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] g, input logic signed [15:0] o, input logic [31:0] s);
    cfg_data = {s, o, g};
    idle(2);
  endtask

  initial begin
    aresetn       = 1'b0;
    enable        = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    cfg_data      = '0;
    repeat (3) tick();
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_state", ramp_state, 0);
    chk("rst_done", ramp_done, 0);
    aresetn = 1'b1;

    // Idle channel: only the offset reaches the output.
    set_cfg(16'h8000, 16'sd100, 32'h0800_0000);
    for (int i = 0; i < 6; i++) drv(16'sd1234, 100);
    chk("idle_state", ramp_state, 0);
    idle(4);

    // Ramp up in 16 samples of 500 LSB each.
    set_cfg(16'h8000, 16'sd0, 32'h0800_0000);
    enable = 1'b1;
    idle(1);
    chk("up_entry", ramp_state, 1);
    for (int k = 0; k < 16; k++) begin
      drv(16'sd8000, 500 * k);
      if (k == 14) chk("up_k14", ramp_state, 1);
    end
    chk("hold_at16", ramp_state, 2);
    for (int i = 0; i < 3; i++) drv(16'sd8000, 8000);
    idle(4);

    // Ramp down from HOLD back to IDLE.
    enable = 1'b0;
    idle(1);
    chk("down_entry", ramp_state, 3);
    for (int k = 0; k < 16; k++) drv(16'sd8000, 8000 - 500 * k);
    chk("down_idle", ramp_state, 0);
    chk("done_pulse", ramp_done, 1);
    tick();
    chk("done_clear", ramp_done, 0);
    drv(16'sd8000, 0);
    drv(16'sd8000, 0);
    idle(4);

    // Reverse at half scale: the ramp-down starts exactly at UNITY/2.
    enable = 1'b1;
    idle(1);
    for (int k = 0; k < 8; k++) drv(16'sd8000, 500 * k);
    chk("half_up", ramp_state, 1);
    enable = 1'b0;
    idle(1);
    chk("half_rev", ramp_state, 3);
    for (int k = 0; k < 8; k++) drv(16'sd8000, 4000 - 500 * k);
    chk("half_idle", ramp_state, 0);
    chk("half_done", ramp_done, 1);
    idle(4);

    // Bypass step, full-scale gain: clamp at both rails, with bubbles.
    set_cfg(16'hFFFF, 16'sd1000, 32'h0);
    enable = 1'b1;
    idle(1);
    drv(16'sd8191, 1000);
    chk("bypass_hold", ramp_state, 2);
    for (int i = 0; i < 5; i++) drv(16'sd8191, 8191);
    drv(16'sd8191, 8191);
    idle(2);
    drv(-16'sd8191, -8191);
    idle(1);
    drv(-16'sd8191, -8191);
    drv(-16'sd8191, -8191);
    idle(4);
    chk("hold_last", m_axis_tdata, -8191);
`ifdef DAC_ENVELOPE_CLIP_COUNT_EN
    chk("clip_count", clip_count, 9);
`endif

    // Half gain with negative offset; shifts floor toward -inf.
    set_cfg(16'h4000, -16'sd50, 32'h0);
    drv(-16'sd1000, -550);
    drv(16'sd3, -49);
    drv(-16'sd3, -52);
    idle(4);

    // Reset in the middle of a ramp-up aborts everything at once.
    enable  = 1'b0;
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    set_cfg(16'h8000, 16'sd0, 32'h0800_0000);
    enable = 1'b1;
    idle(1);
    for (int k = 0; k < 5; k++) drv(16'sd8000, 500 * k);
    chk("pre_rst_state", ramp_state, 1);
    aresetn       = 1'b0;
    enable        = 1'b0;
    s_axis_tvalid = 1'b1;
    tick();
    chk("mid_rst_tdata", m_axis_tdata, 0);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_state", ramp_state, 0);
    chk("mid_rst_done", ramp_done, 0);
`ifdef DAC_ENVELOPE_CLIP_COUNT_EN
    chk("mid_rst_clip", clip_count, 0);
`endif
    s_axis_tvalid = 1'b0;
    aresetn       = 1'b1;
    sb.delete();
    idle(4);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
